approx_rec_mult_pipe: RTL and testbench
=======================================

Name: approx_rec_mult_pipe

Overview:
- Parametrised, pipelined, single-level recursive approximate multiplier: WIDTH x WIDTH unsigned operands split into four (WIDTH/2)x(WIDTH/2) quadrant sub-products, shifted and summed.
- Per-transaction quad_mask selects which quadrants are approximated (low TRUNC bits of that sub-product forced to zero); mask 0 gives the exact product.
- Valid/ready streaming interface with full backpressure, a pass-through tag, and a saturating count of approximate results delivered.
- Serves as the configurable successor to the fixed 8-bit recursive multipliers, for error/energy sweeps in one datapath.

Parameters:
- WIDTH, 8, operand width; even and >= 4.
- TRUNC, 2, number of LSBs zeroed in an approximated quadrant sub-product; 0 <= TRUNC <= WIDTH.
- TAG_W, 4, width of the user tag carried alongside each operation.
- CNT_W, 16, width of approx_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- quad_mask  in  4  approximation enable per quadrant: bit0 aL*bL, bit1 aL*bH, bit2 aH*bL, bit3 aH*bH.
- tag_in  in  TAG_W  user tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- y  out  2*WIDTH  product.
- tag_out  out  TAG_W  tag of the result on y.
- out_approx  out  1  result used quadrant_mask != 0.
- approx_cnt  out  CNT_W  saturating count of approximate results delivered.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, out_valid 0, y 0, tag_out 0, out_approx 0, approx_cnt 0. Data registers may hold any value but the outputs listed read 0. Operations in flight are discarded; no result is emitted after reset release for beats accepted before it.
- Handshake: a beat transfers on in_valid && in_ready. A result transfers on out_valid && out_ready. y, tag_out and out_approx are stable while out_valid && !out_ready.
- Pipeline: three stages.
  - S1 registers a, b, quad_mask and tag.
  - S2 registers the four quadrant sub-products. Each is an H x H product, H = WIDTH/2, giving 2H bits. The low TRUNC bits are ANDed to 0 when its mask bit is set.
  - S3 registers y = (HH<<WIDTH) + (LH<<H) + (HL<<H) + LL, computed at full 2*WIDTH width. Saturation is never needed because approximation only lowers the value.
- Latency: 3 cycles from the accepting edge to out_valid, with no stalls. Throughput: 1 result per cycle.
- Stall: a stage advances when its successor is empty or advancing. in_ready = !S1_valid || S1 advances (combinational from out_ready, no extra bubble). Order is strictly preserved; no beat is dropped or duplicated.
- approx_cnt increments by 1 on each output transfer with out_approx = 1. It holds at all-ones once reached.
- Simultaneous accept and deliver in one cycle is legal and keeps the pipeline full.
- TRUNC = 0 makes every mask value exact, while out_approx still reflects the mask.

Decomposition:
- Shared package approx_mult_pkg holds:
  - the quadrant index constants QLL = 0, QLH = 1, QHL = 2, QHH = 3;
  - a function trunc_lsb(value, n) used by both RTL and the bench model.
- One sub-module, approx_quad_mult: an H x H product with a truncate-enable input. It is instantiated four times in S2.
- Pipeline control stays in the top module.

Test Plan:
- WIDTH = 8, TRUNC = 2, a = 0xFF, b = 0xFF, mask = 0x0, out_ready held 1 -> y = 0xFE01 exactly 3 cycles after accept, out_approx = 0, approx_cnt = 0.
- Same operands with mask 0x1, 0x8 and 0xF back-to-back -> y = 0xFE00, 0xFD01, 0xFCE0 on consecutive cycles, tags in order, approx_cnt = 3.
- out_ready low for 5 cycles while 4 beats are offered -> in_ready drops after 3 accepts. y and tag_out are held stable. After out_ready rises, all 4 results emerge in order with no loss.
- Assert rst_n low for 1 cycle with 2 beats in flight -> out_valid and approx_cnt read 0 immediately. No stale result appears after release.
- Preload approx_cnt near saturation (CNT_W = 4), then deliver 20 approximate results -> approx_cnt stops at 0xF.
- 10k random a, b, mask with random out_ready -> every y matches the package reference model, and the tag sequence is preserved.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate recursive multiplier.
// Holds the quadrant index constants and the LSB truncation helper used by
// the datapath and by the bench reference model.
package approx_mult_pkg;

    // Quadrant indices: bit i of quad_mask approximates sub-product i.
    localparam int unsigned QLL = 0;   // aL * bL
    localparam int unsigned QLH = 1;   // aL * bH
    localparam int unsigned QHL = 2;   // aH * bL
    localparam int unsigned QHH = 3;   // aH * bH
    localparam int unsigned NQ  = 4;

    // Widest value trunc_lsb handles; callers zero-extend into it.
    localparam int unsigned MAX_W = 64;

    // Clear the n least-significant bits of value (n >= MAX_W clears all).
    function automatic logic [MAX_W-1:0] trunc_lsb(input logic [MAX_W-1:0] value,
                                                    input int unsigned      n);
        logic [MAX_W-1:0] keep;
        keep = (n >= MAX_W) ? '0 : ({MAX_W{1'b1}} << n);
        return value & keep;
    endfunction

endpackage

// File: rtl/approx_rec_mult_pipe_if.sv
// Streaming bus of the approximate multiplier.
//   in_valid/in_ready : operand beat handshake (a, b, quad_mask, tag_in)
//   out_valid/out_ready : result handshake (y, tag_out, out_approx)
// master = traffic source/sink around the block, slave = the multiplier.
interface approx_rec_mult_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [3:0]           quad_mask;
    logic [TAG_W-1:0]     tag_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   y;
    logic [TAG_W-1:0]     tag_out;
    logic                 out_approx;

    modport master (
        output in_valid, a, b, quad_mask, tag_in, out_ready,
        input  in_ready, out_valid, y, tag_out, out_approx
    );

    modport slave (
        input  in_valid, a, b, quad_mask, tag_in, out_ready,
        output in_ready, out_valid, y, tag_out, out_approx
    );
endinterface

// File: rtl/approx_quad_mult.sv
// One H x H unsigned quadrant product with optional LSB truncation.
//   x, w     : H-bit operand halves
//   trunc_en : zero the low TRUNC bits of the product
//   p_c      : 2H-bit product (combinational)
module approx_quad_mult
    import approx_mult_pkg::*;
#(
    parameter int unsigned H     = 4,
    parameter int unsigned TRUNC = 2
) (
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   w,
    input  logic           trunc_en,
    output logic [2*H-1:0] p_c
);
    localparam int unsigned PW = 2 * H;

    logic [PW-1:0] prod;

    // Exact product, then optional truncation through the shared helper.
    always_comb begin
        prod = PW'(x) * PW'(w);
        p_c  = prod;
        if (trunc_en) begin
            p_c = PW'(trunc_lsb(MAX_W'(prod), TRUNC));
        end
    end
endmodule

// File: rtl/approx_rec_mult_pipe.sv
// Three-stage pipelined single-level recursive approximate multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the valid/ready operand/result stream
//   approx_cnt : saturating count of delivered approximate results
// S1 registers operands, S2 the four quadrant sub-products, S3 the sum.
module approx_rec_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TRUNC = 2,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    approx_rec_mult_pipe_if.slave bus,
    output logic [CNT_W-1:0]      approx_cnt
);
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned QW = 2 * H;
    localparam int unsigned PW = 2 * WIDTH;

    logic                  s1_valid;
    logic [WIDTH-1:0]      s1_a;
    logic [WIDTH-1:0]      s1_b;
    logic [3:0]            s1_mask;
    logic [TAG_W-1:0]      s1_tag;

    logic                  s2_valid;
    logic [NQ-1:0][QW-1:0] s2_q;
    logic                  s2_approx;
    logic [TAG_W-1:0]      s2_tag;

    logic [NQ-1:0][QW-1:0] q_c;
    logic [PW-1:0]         y_c;
    logic                  s1_load_c;
    logic                  s2_load_c;
    logic                  s3_load_c;

    // A stage may load when it is empty or its contents leave this cycle.
    always_comb begin
        s3_load_c = !bus.out_valid || bus.out_ready;
        s2_load_c = !s2_valid || s3_load_c;
        s1_load_c = !s1_valid || s2_load_c;
    end

    assign bus.in_ready = s1_load_c;

    // Quadrant q uses aH when q[1] is set and bH when q[0] is set.
    for (genvar qi = 0; qi < NQ; qi++) begin : g_quad
        logic [H-1:0] x_c;
        logic [H-1:0] w_c;
        assign x_c = (qi >= 2)     ? s1_a[WIDTH-1:H] : s1_a[H-1:0];
        assign w_c = (qi % 2 == 1) ? s1_b[WIDTH-1:H] : s1_b[H-1:0];
        approx_quad_mult #(.H(H), .TRUNC(TRUNC)) u_quad (
            .x        (x_c),
            .w        (w_c),
            .trunc_en (s1_mask[qi]),
            .p_c      (q_c[qi])
        );
    end

    // Recombine at full product width; truncation only lowers the sum.
    always_comb begin
        y_c = (PW'(s2_q[QHH]) << WIDTH)
            + (PW'(s2_q[QLH]) << H)
            + (PW'(s2_q[QHL]) << H)
            +  PW'(s2_q[QLL]);
    end

    // S1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mask  <= '0;
            s1_tag   <= '0;
        end else if (s1_load_c) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a    <= bus.a;
                s1_b    <= bus.b;
                s1_mask <= bus.quad_mask;
                s1_tag  <= bus.tag_in;
            end
        end
    end

    // S2: quadrant sub-products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_q      <= '0;
            s2_approx <= 1'b0;
            s2_tag    <= '0;
        end else if (s2_load_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q      <= q_c;
                s2_approx <= |s1_mask;
                s2_tag    <= s1_tag;
            end
        end
    end

    // S3: output register; holds while out_valid && !out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.y          <= '0;
            bus.tag_out    <= '0;
            bus.out_approx <= 1'b0;
        end else if (s3_load_c) begin
            bus.out_valid <= s2_valid;
            if (s2_valid) begin
                bus.y          <= y_c;
                bus.tag_out    <= s2_tag;
                bus.out_approx <= s2_approx;
            end
        end
    end

    // Count delivered approximate results, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            approx_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.out_approx
                     && (approx_cnt != '1)) begin
            approx_cnt <= approx_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_approx_rec_mult_pipe.sv
// Directed and random checks of approx_rec_mult_pipe (WIDTH 8, TRUNC 2),
// plus a CNT_W 4 instance for counter saturation.
module tb_approx_rec_mult_pipe;
    import approx_mult_pkg::*;

    localparam int unsigned N_RND = 10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    approx_rec_mult_pipe_if #(.WIDTH(8), .TAG_W(4)) bus ();
    approx_rec_mult_pipe_if #(.WIDTH(8), .TAG_W(4)) bus_s ();

    approx_rec_mult_pipe #(.WIDTH(8), .TRUNC(2), .TAG_W(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .approx_cnt (cnt_a)
    );

    approx_rec_mult_pipe #(.WIDTH(8), .TRUNC(2), .TAG_W(4), .CNT_W(4)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_s),
        .approx_cnt (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] m, input logic [3:0] t);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.quad_mask = m;
        bus.tag_in    = t;
    endtask

    // Reference: nibble decomposition by division, truncation via the package.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] m);
        int unsigned al = a % 16;
        int unsigned ah = a / 16;
        int unsigned bl = b % 16;
        int unsigned bh = b / 16;
        logic [63:0] ll, lh, hl, hh;
        ll = 64'(al * bl);
        lh = 64'(al * bh);
        hl = 64'(ah * bl);
        hh = 64'(ah * bh);
        if (m[0]) ll = trunc_lsb(ll, 2);
        if (m[1]) lh = trunc_lsb(lh, 2);
        if (m[2]) hl = trunc_lsb(hl, 2);
        if (m[3]) hh = trunc_lsb(hh, 2);
        return 16'(hh * 256 + (lh + hl) * 16 + ll);
    endfunction

    logic [7:0]  bp_a   [4] = '{8'h12, 8'hA5, 8'h07, 8'hFF};
    logic [7:0]  bp_b   [4] = '{8'h34, 8'h5A, 8'hFF, 8'h01};
    logic [3:0]  bp_m   [4] = '{4'h0,  4'h0,  4'h0,  4'h4};
    logic [15:0] bp_y   [4] = '{16'h03A8, 16'h3A02, 16'h06F9, 16'h00CF};

    logic [15:0] q_y   [$];
    logic [3:0]  q_tag [$];
    logic        q_ap  [$];

    initial begin
        int unsigned n_acc;
        int unsigned k;
        int unsigned seen;
        int unsigned sent;
        int unsigned got;
        int unsigned spurious;
        int unsigned ap_seen;

        rst_n = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 4'h0, 4'h0);
        bus.out_ready    = 1'b0;
        bus_s.in_valid   = 1'b0;
        bus_s.a          = 8'h00;
        bus_s.b          = 8'h00;
        bus_s.quad_mask  = 4'h0;
        bus_s.tag_in     = 4'h0;
        bus_s.out_ready  = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_out_valid",  64'(bus.out_valid),  64'h0);
        chk("rst_y",          64'(bus.y),          64'h0);
        chk("rst_tag_out",    64'(bus.tag_out),    64'h0);
        chk("rst_out_approx", 64'(bus.out_approx), 64'h0);
        chk("rst_cnt_a",      64'(cnt_a),          64'h0);
        chk("rst_cnt_b",      64'(cnt_b),          64'h0);
        chk("rst_in_ready",   64'(bus.in_ready),   64'h1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Exact product; result registered at the third edge counting the accept
        drive(1'b1, 8'hFF, 8'hFF, 4'h0, 4'h1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'h0, 4'h0);
        chk("lat_e0_valid", 64'(bus.out_valid), 64'h0);
        tick();
        chk("lat_e1_valid", 64'(bus.out_valid), 64'h0);
        tick();
        chk("lat_e2_valid",  64'(bus.out_valid),  64'h1);
        chk("exact_y",       64'(bus.y),          64'hFE01);
        chk("exact_tag",     64'(bus.tag_out),    64'h1);
        chk("exact_approx",  64'(bus.out_approx), 64'h0);
        tick();
        chk("exact_drained", 64'(bus.out_valid),  64'h0);
        chk("exact_cnt",     64'(cnt_a),          64'h0);

        // Back-to-back approximate masks
        drive(1'b1, 8'hFF, 8'hFF, 4'h1, 4'h2);
        tick();
        drive(1'b1, 8'hFF, 8'hFF, 4'h8, 4'h3);
        tick();
        drive(1'b1, 8'hFF, 8'hFF, 4'hF, 4'h4);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'h0, 4'h0);
        chk("m1_y",      64'(bus.y),          64'hFE00);
        chk("m1_tag",    64'(bus.tag_out),    64'h2);
        chk("m1_approx", 64'(bus.out_approx), 64'h1);
        tick();
        chk("m8_y",   64'(bus.y),       64'hFD01);
        chk("m8_tag", 64'(bus.tag_out), 64'h3);
        tick();
        chk("mf_y",   64'(bus.y),       64'hFCE0);
        chk("mf_tag", 64'(bus.tag_out), 64'h4);
        tick();
        chk("b2b_drained", 64'(bus.out_valid), 64'h0);
        chk("b2b_cnt",     64'(cnt_a),         64'h3);

        // Backpressure: out_ready low for 5 cycles while 4 beats are offered
        bus.out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 5; c++) begin
            if (n_acc < 4) drive(1'b1, bp_a[n_acc], bp_b[n_acc], bp_m[n_acc], 4'(5 + n_acc));
            #1;
            if (bus.out_valid) begin
                chk("bp_hold_y",   64'(bus.y),       64'h03A8);
                chk("bp_hold_tag", 64'(bus.tag_out), 64'h5);
            end
            if (bus.in_valid && bus.in_ready) n_acc++;
            tick();
        end
        chk("bp_accepts",  64'(n_acc),         64'h3);
        chk("bp_in_ready", 64'(bus.in_ready),  64'h0);
        chk("bp_valid",    64'(bus.out_valid), 64'h1);
        chk("bp_y",        64'(bus.y),         64'h03A8);
        chk("bp_tag",      64'(bus.tag_out),   64'h5);
        bus.out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (n_acc < 4) drive(1'b1, bp_a[n_acc], bp_b[n_acc], bp_m[n_acc], 4'(5 + n_acc));
            else           bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) begin
                chk("bp_out_y",   64'(bus.y),       64'(bp_y[k]));
                chk("bp_out_tag", 64'(bus.tag_out), 64'(5 + k));
                k++;
            end
            if (bus.in_valid && bus.in_ready) n_acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_delivered", 64'(k),     64'h4);
        chk("bp_cnt",       64'(cnt_a), 64'h4);

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        drive(1'b1, 8'hFF, 8'hFF, 4'hF, 4'h9);
        tick();
        drive(1'b1, 8'hFF, 8'hFF, 4'hF, 4'hA);
        tick();
        drive(1'b0, 8'h00, 8'h00, 4'h0, 4'h0);
        tick();
        chk("pre_rst_valid", 64'(bus.out_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'h0);
        chk("mid_rst_cnt",   64'(cnt_a),         64'h0);
        chk("mid_rst_y",     64'(bus.y),         64'h0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("no_stale", 64'(seen), 64'h0);

        // Random operands, masks and backpressure against the model
        sent = 0;
        got = 0;
        spurious = 0;
        ap_seen = 0;
        for (int c = 0; c < 40000 && got < N_RND; c++) begin
            bus.out_ready = ($urandom_range(3) != 0);
            if (sent < N_RND && $urandom_range(3) != 0)
                drive(1'b1, 8'($urandom), 8'($urandom), 4'($urandom), 4'(sent));
            else
                bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q_y.size() == 0) begin
                    spurious++;
                end else begin
                    chk("rnd_y",      64'(bus.y),          64'(q_y.pop_front()));
                    chk("rnd_tag",    64'(bus.tag_out),    64'(q_tag.pop_front()));
                    chk("rnd_approx", 64'(bus.out_approx), 64'(q_ap.pop_front()));
                    if (bus.out_approx) ap_seen++;
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q_y.push_back(model(bus.a, bus.b, bus.quad_mask));
                q_tag.push_back(bus.tag_in);
                q_ap.push_back(|bus.quad_mask);
                sent++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("rnd_delivered", 64'(got),      64'(N_RND));
        chk("rnd_spurious",  64'(spurious), 64'h0);
        chk("rnd_cnt",       64'(cnt_a),    64'(ap_seen));

        // Saturation of a 4-bit counter over 20 approximate results
        bus_s.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus_s.in_valid  = 1'b1;
            bus_s.a         = 8'hFF;
            bus_s.b         = 8'hFF;
            bus_s.quad_mask = 4'h1;
            bus_s.tag_in    = 4'(i);
            tick();
            if (i == 11) chk("sat_mid", 64'(cnt_b), 64'h9);
        end
        bus_s.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("sat_final", 64'(cnt_b), 64'hF);
        chk("sat_drained", 64'(bus_s.out_valid), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
